seq_mem_stream_reader: RTL and testbench

- Initiator for a single-port sequential memory read port (addr0 / content_en / write_en / read_data / done).
- On go, reads len consecutive words starting at base_addr and presents them as a ready/valid output stream.
- A 2-entry output FIFO absorbs backpressure and sustains one word per cycle.
- Sits between a seq_mem_d1 instance and a streaming consumer, such as a compute pipeline or DMA egress.

---
 rtl/seq_mem_stream_reader.sv | 139 +++++++++++++
 tb/tb_seq_mem_stream_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mem_stream_reader.sv
// Sequential-memory burst reader: fetches len words from base_addr on a
// seq_mem_d1 style port and presents them as a ready/valid stream via a 2-deep FIFO.
module seq_mem_stream_reader #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4,
  parameter int LEN_SIZE = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE-1:0] base_addr,
  input  logic [LEN_SIZE-1:0] len,
  output logic                done,
  output logic                error,
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic                mem_content_en,
  output logic                mem_write_en,
  output logic [WIDTH-1:0]    mem_write_data,
  input  logic [WIDTH-1:0]    mem_read_data,
  input  logic                mem_done,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int CW = ((IDX_SIZE > LEN_SIZE) ? IDX_SIZE : LEN_SIZE) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state, state_next;
  logic [IDX_SIZE-1:0] issue_addr;
  logic [LEN_SIZE-1:0] remaining_issue;
  logic [LEN_SIZE-1:0] remaining_pop;
  logic                inflight;
  logic [WIDTH-1:0]    fifo_q [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;
  logic                issue;
  logic                push;
  logic                pop;
  logic [2:0]          occupancy;
  logic [CW-1:0]       end_addr;
  logic                out_of_bounds;

  // End address is computed one bit wider than either operand so it cannot wrap.
  assign end_addr       = CW'(base_addr) + CW'(len);
  assign out_of_bounds  = end_addr > CW'(SIZE);

  assign pop            = out_valid && out_ready;
  assign push           = inflight && mem_done;
  assign occupancy      = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  assign out_valid      = (count != 2'd0);
  assign out_data       = out_valid ? fifo_q[rd_ptr] : '0;
  assign done           = (state == DONE);

  assign mem_content_en = issue;
  assign mem_addr0      = issue ? issue_addr : '0;
  assign mem_write_en   = 1'b0;
  assign mem_write_data = '0;

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          if (len == '0 || out_of_bounds) state_next = DONE;
          else                            state_next = RUN;
        end
      end
      RUN: begin
        // Only issue when the word is guaranteed a FIFO slot on arrival.
        issue = (remaining_issue != '0) && (occupancy < 3'd2);
        if (pop && remaining_pop == LEN_SIZE'(1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      issue_addr      <= '0;
      remaining_issue <= '0;
      remaining_pop   <= '0;
      inflight        <= 1'b0;
      error           <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && go) begin
        issue_addr      <= base_addr;
        remaining_issue <= len;
        remaining_pop   <= len;
        error           <= (len != '0) && out_of_bounds;
      end else begin
        if (issue) begin
          issue_addr      <= issue_addr + IDX_SIZE'(1);
          remaining_issue <= remaining_issue - LEN_SIZE'(1);
        end
        if (pop) remaining_pop <= remaining_pop - LEN_SIZE'(1);
      end
      if (issue)     inflight <= 1'b1;
      else if (push) inflight <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= mem_read_data;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
    !(push && count == 2'd2));

endmodule

// File: tb/tb_seq_mem_stream_reader.sv
// Bench for seq_mem_stream_reader: table vectors, randomized transfers and a
// mid-transfer reset, checked against a word-list model of the memory.
module tb_seq_mem_stream_reader;

  typedef struct {
    logic [3:0] base;
    logic [4:0] len;
    int         lowCycles;
    bit         randReady;
    bit         expError;
    int         expWords;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic [3:0]  base_addr = '0;
  logic [4:0]  len = '0;
  logic        done;
  logic        error;
  logic [3:0]  mem_addr0;
  logic        mem_content_en;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = '0;
  logic        mem_done = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  logic [31:0] memArray [16];
  vec_t        vectors [9];

  int checkCount = 0;
  int passCount = 0;
  int cycleNo = 0;
  int goCycle = 0;
  int issuesAtRelease = 0;
  bit finished = 1'b0;

  int issuedCnt = 0;
  int poppedCnt = 0;
  int maxOcc = 0;
  int stableErr = 0;
  int doneCount = 0;
  int doneCycle = 0;
  int validSeen = 0;
  int writeSeen = 0;
  logic        prevStall = 1'b0;
  logic [31:0] prevData = '0;

  logic [31:0] gotQ [$];
  logic [3:0]  addrQ [$];
  int          issueCycQ [$];
  int          popCycQ [$];

  int doneBase, stableBase, validBase;

  seq_mem_stream_reader dut (
    .clk            (clk),
    .reset          (reset),
    .go             (go),
    .base_addr      (base_addr),
    .len            (len),
    .done           (done),
    .error          (error),
    .mem_addr0      (mem_addr0),
    .mem_content_en (mem_content_en),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_done       (mem_done),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  // One-cycle-latency memory: data and done appear the cycle after the request.
  always @(posedge clk) begin
    mem_done <= mem_content_en;
    if (mem_content_en) mem_read_data <= memArray[mem_addr0];
  end

  // Observe the DUT mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      prevStall <= 1'b0;
      poppedCnt <= issuedCnt;
    end else begin
      if (prevStall && !(out_valid && out_data == prevData)) stableErr <= stableErr + 1;
      if (issuedCnt - poppedCnt > maxOcc) maxOcc <= issuedCnt - poppedCnt;
      if (mem_content_en) begin
        addrQ.push_back(mem_addr0);
        issueCycQ.push_back(cycleNo);
        issuedCnt <= issuedCnt + 1;
      end
      if (out_valid && out_ready) begin
        gotQ.push_back(out_data);
        popCycQ.push_back(cycleNo);
        poppedCnt <= poppedCnt + 1;
      end
      if (done) begin
        doneCount <= doneCount + 1;
        doneCycle <= cycleNo;
      end
      if (out_valid) validSeen <= validSeen + 1;
      if (mem_write_en || mem_write_data != '0) writeSeen <= writeSeen + 1;
      prevStall <= out_valid && !out_ready;
      prevData  <= out_data;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input vec_t v);
    gotQ.delete();
    addrQ.delete();
    issueCycQ.delete();
    popCycQ.delete();
    finished = 1'b0;
    issuesAtRelease = 0;
    @(posedge clk); #1;
    doneBase   = doneCount;
    stableBase = stableErr;
    validBase  = validSeen;
    out_ready  = 1'b0;
    go         = 1'b1;
    base_addr  = v.base;
    len        = v.len;
    goCycle    = cycleNo;
    @(posedge clk); #1;
    go = 1'b0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      if (cyc < v.lowCycles) out_ready = 1'b0;
      else if (v.randReady)  out_ready = 1'($urandom_range(0, 1));
      else                   out_ready = 1'b1;
      if (cyc == v.lowCycles) issuesAtRelease = addrQ.size();
      @(negedge clk);
      if (done) finished = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic verifyVector(input string tag, input vec_t v);
    int n;
    applyStimulus(v);
    checkOutput({tag, " finished"}, 32'(finished), 32'd1);
    checkOutput({tag, " error"}, 32'(error), 32'(v.expError));
    checkOutput({tag, " done pulses"}, 32'(doneCount - doneBase), 32'd1);
    checkOutput({tag, " word count"}, 32'(gotQ.size()), 32'(v.expWords));
    checkOutput({tag, " read count"}, 32'(addrQ.size()), 32'(v.expWords));
    n = (gotQ.size() < v.expWords) ? gotQ.size() : v.expWords;
    for (int k = 0; k < n; k++)
      checkOutput($sformatf("%s data%0d", tag, k), gotQ[k], memArray[v.base + k]);
    n = (addrQ.size() < v.expWords) ? addrQ.size() : v.expWords;
    for (int k = 0; k < n; k++)
      checkOutput($sformatf("%s addr%0d", tag, k), 32'(addrQ[k]), 32'(v.base + k));
    checkOutput({tag, " stall stable"}, 32'(stableErr - stableBase), 32'd0);
    checkOutput({tag, " occupancy<=2"}, 32'(maxOcc <= 2), 32'd1);
    if (v.expWords == 0) begin
      checkOutput({tag, " done latency"}, 32'(doneCycle - goCycle), 32'd1);
      checkOutput({tag, " no valid"}, 32'(validSeen - validBase), 32'd0);
    end else if (gotQ.size() > 0 && addrQ.size() > 0) begin
      checkOutput({tag, " first issue"}, 32'(issueCycQ[0] - goCycle), 32'd1);
      checkOutput({tag, " done after last pop"}, 32'(doneCycle), 32'(popCycQ[popCycQ.size()-1] + 1));
      if (v.lowCycles == 0 && !v.randReady) begin
        checkOutput({tag, " fill latency"}, 32'(popCycQ[0] - issueCycQ[0]), 32'd2);
        checkOutput({tag, " issue burst"}, 32'(issueCycQ[issueCycQ.size()-1] - issueCycQ[0]), 32'(v.expWords - 1));
        checkOutput({tag, " output burst"}, 32'(popCycQ[popCycQ.size()-1] - popCycQ[0]), 32'(v.expWords - 1));
      end else begin
        checkOutput({tag, " min latency"}, 32'(popCycQ[0] - issueCycQ[0] >= 2), 32'd1);
      end
      if (v.lowCycles >= 3 && v.expWords >= 2)
        checkOutput({tag, " issues before stall"}, 32'(issuesAtRelease), 32'd2);
    end
  endtask

  initial begin
    vec_t rv;
    int endAddr;
    for (int i = 0; i < 16; i++) memArray[i] = $urandom;
    memArray[3] = 32'h0000_000A;
    memArray[4] = 32'h0000_000B;
    memArray[5] = 32'h0000_000C;
    memArray[6] = 32'h0000_000D;

    vectors[0] = '{4'd3,  5'd4,  0, 1'b0, 1'b0, 4};
    vectors[1] = '{4'd0,  5'd5,  6, 1'b0, 1'b0, 5};
    vectors[2] = '{4'd5,  5'd0,  0, 1'b0, 1'b0, 0};
    vectors[3] = '{4'd14, 5'd3,  0, 1'b0, 1'b1, 0};
    vectors[4] = '{4'd0,  5'd1,  0, 1'b0, 1'b0, 1};
    vectors[5] = '{4'd0,  5'd16, 0, 1'b1, 1'b0, 16};
    vectors[6] = '{4'd12, 5'd4,  0, 1'b0, 1'b0, 4};
    vectors[7] = '{4'd15, 5'd2,  0, 1'b0, 1'b1, 0};
    vectors[8] = '{4'd0,  5'd16, 4, 1'b1, 1'b0, 16};

    #2;
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset error", 32'(error), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    checkOutput("reset content_en", 32'(mem_content_en), 32'd0);
    checkOutput("reset addr0", 32'(mem_addr0), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) verifyVector($sformatf("vec%0d", i), vectors[i]);

    // Randomized transfers; the model is simply the memory slice base..base+len-1.
    for (int r = 0; r < 6; r++) begin
      rv.base      = 4'($urandom_range(0, 15));
      rv.len       = 5'($urandom_range(0, 16));
      rv.lowCycles = $urandom_range(0, 4);
      rv.randReady = 1'b1;
      endAddr      = int'(rv.base) + int'(rv.len);
      rv.expError  = (rv.len != 0) && (endAddr > 16);
      rv.expWords  = (rv.len == 0 || rv.expError) ? 0 : int'(rv.len);
      verifyVector($sformatf("rand%0d", r), rv);
    end

    // Reset asserted while words are still streaming out.
    gotQ.delete();
    @(posedge clk); #1;
    doneBase  = doneCount;
    out_ready = 1'b1;
    go        = 1'b1;
    base_addr = 4'd3;
    len       = 5'd4;
    @(posedge clk); #1;
    go = 1'b0;
    for (int c = 0; c < 20 && gotQ.size() < 2; c++) begin
      @(posedge clk); #1;
    end
    checkOutput("midreset two words", 32'(gotQ.size()), 32'd2);
    #2 reset = 1'b0;
    #1;
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset out_data", out_data, 32'd0);
    checkOutput("midreset content_en", 32'(mem_content_en), 32'd0);
    checkOutput("midreset addr0", 32'(mem_addr0), 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    checkOutput("midreset error", 32'(error), 32'd0);
    #3 reset = 1'b1;
    validBase = validSeen;
    @(posedge clk); #1;
    checkOutput("late mem_done ignored", 32'(out_valid), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("midreset no done", 32'(doneCount - doneBase), 32'd0);
    checkOutput("midreset no valid", 32'(validSeen - validBase), 32'd0);
    out_ready = 1'b0;
    rv = '{4'd8, 5'd3, 0, 1'b0, 1'b0, 3};
    verifyVector("after reset", rv);

    checkOutput("no writes", 32'(writeSeen), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
